// File: rtl/fifo_read_streamer_if.sv
// Read-side bundle: the FIFO read port plus the outgoing valid/ready stream.
// The master modport is the streamer; the slave modport is the FIFO and the consumer.
interface fifo_read_streamer_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  read_enable;
    logic                  rempty;
    logic [DATA_WIDTH-1:0] data_read;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_ready;

    modport master (
        output read_enable,
        input  rempty,
        input  data_read,
        output m_data,
        output m_valid,
        input  m_ready
    );

    modport slave (
        input  read_enable,
        output rempty,
        output data_read,
        input  m_data,
        input  m_valid,
        output m_ready
    );
endinterface

// File: rtl/fifo_read_streamer.sv
// Pops the async FIFO read port and re-presents the words as a valid/ready stream
// through a 2-entry buffer, sustaining one word per cycle.
//
// state | meaning
// OCC0  | buffer empty
// OCC1  | one word held, head in buf0
// OCC2  | two words held, head in buf0, next in buf1
module fifo_read_streamer #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 rclk_i,
    input  logic                 rrst_n_i,
    input  logic                 enable_i,
    fifo_read_streamer_if.master bus,
    output logic [CNT_WIDTH-1:0] word_count_o,
    output logic                 busy_o
);
    typedef enum logic [1:0] {
        OCC0 = 2'd0,
        OCC1 = 2'd1,
        OCC2 = 2'd2
    } occ_e;

    occ_e                  state_q, state_d;
    logic                  inflight_q;
    logic [DATA_WIDTH-1:0] buf0_q, buf0_d;
    logic [DATA_WIDTH-1:0] buf1_q, buf1_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic                  push;
    logic                  pop_out;
    logic                  pop_req;
    logic                  room;
    logic [1:0]            level;

    assign push    = inflight_q;
    assign pop_out = (state_q != OCC0) & bus.m_ready;
    assign level   = state_q + {1'b0, inflight_q};

    // Room for one more pop once the committed words (held + in flight), less the
    // one leaving this cycle, stay below the buffer depth.
    assign room    = (level < 2'd2) | ((level == 2'd2) & pop_out);
    assign pop_req = rrst_n_i & enable_i & ~bus.rempty & room;

    assign bus.read_enable = pop_req;
    assign bus.m_valid     = (state_q != OCC0);
    assign bus.m_data      = buf0_q;
    assign word_count_o    = count_q;
    assign busy_o          = inflight_q | (state_q != OCC0);
    assign count_d         = count_q + CNT_WIDTH'(pop_out);

    always_comb begin
        state_d = state_q;
        buf0_d  = buf0_q;
        buf1_d  = buf1_q;
        case (state_q)
            OCC0: begin
                if (push) begin
                    buf0_d  = bus.data_read;
                    state_d = OCC1;
                end
            end
            OCC1: begin
                if (push && pop_out) begin
                    buf0_d = bus.data_read;
                end else if (push) begin
                    buf1_d  = bus.data_read;
                    state_d = OCC2;
                end else if (pop_out) begin
                    state_d = OCC0;
                end
            end
            OCC2: begin
                if (pop_out) begin
                    buf0_d = buf1_q;
                    if (push) begin
                        buf1_d = bus.data_read;
                    end else begin
                        state_d = OCC1;
                    end
                end
            end
            default: state_d = OCC0;
        endcase
    end

    always_ff @(posedge rclk_i or negedge rrst_n_i) begin
        if (!rrst_n_i) begin
            state_q    <= OCC0;
            inflight_q <= 1'b0;
            buf0_q     <= '0;
            buf1_q     <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            inflight_q <= pop_req;
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
            count_q    <= count_d;
        end
    end

    a_no_overflow: assert property (@(posedge rclk_i) disable iff (!rrst_n_i)
        !(push && (state_q == OCC2) && !pop_out));

endmodule
